// File: rtl/fwd_select_unit_pkg.sv
// Shared definitions for the EX-stage operand forwarding controller.
// The select encodings below are tied to the physical input order of the
// EX-stage operand MUX4: IN0 regfile, IN1 MEM result, IN2 WB result,
// IN3 retire latch.
package fwd_select_unit_pkg;

  localparam int DEF_REG_AW = 4;
  localparam int DEF_PC_REG = 15;

  typedef enum logic [1:0] {
    SEL_RF  = 2'b00,
    SEL_MEM = 2'b01,
    SEL_WB  = 2'b10,
    SEL_RET = 2'b11
  } fwd_sel_e;

  // Producer in EX reaches MEM next cycle, MEM reaches WB, WB reaches the
  // retire latch; the youngest producer always takes priority.
  function automatic fwd_sel_e pick_sel(input logic ex_hit,
                                        input logic mem_hit,
                                        input logic wb_hit);
    fwd_sel_e sel;
    if (ex_hit) begin
      sel = SEL_MEM;
    end else if (mem_hit) begin
      sel = SEL_WB;
    end else if (wb_hit) begin
      sel = SEL_RET;
    end else begin
      sel = SEL_RF;
    end
    return sel;
  endfunction

endpackage

// File: rtl/fwd_select_unit_match.sv
// Combinational tag matcher for one source operand. Compares a decode-stage
// source index against the EX/MEM/WB destination tags and returns the
// forwarding select plus a flag for a load sitting in EX (load-use).
module fwd_select_unit_match
  import fwd_select_unit_pkg::*;
#(
  parameter int REG_AW = DEF_REG_AW,
  parameter int PC_REG = DEF_PC_REG
) (
  input  logic [REG_AW-1:0] src,
  input  logic              used,
  input  logic              ex_v,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_we,
  input  logic              ex_ld,
  input  logic              mem_v,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_we,
  input  logic              wb_v,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_we,
  output logic [1:0]        sel,
  output logic              load_hit
);

  localparam logic [REG_AW-1:0] PC_IDX = PC_REG[REG_AW-1:0];

  logic ex_hit_s;
  logic mem_hit_s;
  logic wb_hit_s;

  // A stage only matches when it holds a live producer of a non-PC register.
  always_comb begin
    ex_hit_s  = ex_v  & ex_we  & (ex_rd  != PC_IDX) & (ex_rd  == src);
    mem_hit_s = mem_v & mem_we & (mem_rd != PC_IDX) & (mem_rd == src);
    wb_hit_s  = wb_v  & wb_we  & (wb_rd  != PC_IDX) & (wb_rd  == src);
  end

  // Unused sources and PC reads always come from the register file path.
  always_comb begin
    sel      = SEL_RF;
    load_hit = 1'b0;
    if (!used || (src == PC_IDX)) begin
      sel      = SEL_RF;
      load_hit = 1'b0;
    end else begin
      sel      = pick_sel(ex_hit_s, mem_hit_s, wb_hit_s);
      load_hit = ex_hit_s & ex_ld;
    end
  end

endmodule

// File: rtl/fwd_select_unit.sv
// Operand-forwarding controller: tracks destination tags of instructions in
// EX, MEM and WB, registers the operand-A/B MUX4 selects for the instruction
// entering EX, and requests a one-cycle decode stall on load-use hazards.
module fwd_select_unit
  import fwd_select_unit_pkg::*;
#(
  parameter int REG_AW = DEF_REG_AW,
  parameter int PC_REG = DEF_PC_REG
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rn,
  input  logic              id_rn_used,
  input  logic [REG_AW-1:0] id_rm,
  input  logic              id_rm_used,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_we,
  input  logic              id_is_load,
  input  logic              stall_in,
  input  logic              flush,
  output logic [1:0]        sel_a,
  output logic [1:0]        sel_b,
  output logic              ex_valid,
  output logic              hazard_stall
);

  // Stage tag registers
  logic              ex_v_r;
  logic [REG_AW-1:0] ex_rd_r;
  logic              ex_we_r;
  logic              ex_ld_r;
  logic              mem_v_r;
  logic [REG_AW-1:0] mem_rd_r;
  logic              mem_we_r;
  logic              mem_ld_r;
  logic              wb_v_r;
  logic [REG_AW-1:0] wb_rd_r;
  logic              wb_we_r;
  logic              wb_ld_r;

  logic [1:0]        sel_a_r;
  logic [1:0]        sel_b_r;

  logic [1:0]        sel_a_s;
  logic [1:0]        sel_b_s;
  logic              hit_a_s;
  logic              hit_b_s;
  logic              hazard_s;
  logic              rn_used_s;
  logic              rm_used_s;

  // An invalid decode slot reads nothing, so it can neither forward nor stall.
  always_comb begin
    rn_used_s = id_valid & id_rn_used;
    rm_used_s = id_valid & id_rm_used;
  end

  fwd_select_unit_match #(
    .REG_AW (REG_AW),
    .PC_REG (PC_REG)
  ) u_match_a (
    .src      (id_rn),
    .used     (rn_used_s),
    .ex_v     (ex_v_r),
    .ex_rd    (ex_rd_r),
    .ex_we    (ex_we_r),
    .ex_ld    (ex_ld_r),
    .mem_v    (mem_v_r),
    .mem_rd   (mem_rd_r),
    .mem_we   (mem_we_r),
    .wb_v     (wb_v_r),
    .wb_rd    (wb_rd_r),
    .wb_we    (wb_we_r),
    .sel      (sel_a_s),
    .load_hit (hit_a_s)
  );

  fwd_select_unit_match #(
    .REG_AW (REG_AW),
    .PC_REG (PC_REG)
  ) u_match_b (
    .src      (id_rm),
    .used     (rm_used_s),
    .ex_v     (ex_v_r),
    .ex_rd    (ex_rd_r),
    .ex_we    (ex_we_r),
    .ex_ld    (ex_ld_r),
    .mem_v    (mem_v_r),
    .mem_rd   (mem_rd_r),
    .mem_we   (mem_we_r),
    .wb_v     (wb_v_r),
    .wb_rd    (wb_rd_r),
    .wb_we    (wb_we_r),
    .sel      (sel_b_s),
    .load_hit (hit_b_s)
  );

  // A load still in EX cannot feed the decode instruction; a flush kills the
  // decode instruction anyway, so it suppresses the stall request.
  always_comb begin
    hazard_s = hit_a_s | hit_b_s;
  end

  assign hazard_stall = hazard_s & ~flush;
  assign sel_a        = sel_a_r;
  assign sel_b        = sel_b_r;
  assign ex_valid     = ex_v_r;

  // Pipeline advance: reset, freeze, bubble insertion (flush or load-use), or
  // normal issue of the decode instruction into EX.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_v_r   <= 1'b0;
      ex_rd_r  <= {REG_AW{1'b0}};
      ex_we_r  <= 1'b0;
      ex_ld_r  <= 1'b0;
      mem_v_r  <= 1'b0;
      mem_rd_r <= {REG_AW{1'b0}};
      mem_we_r <= 1'b0;
      mem_ld_r <= 1'b0;
      wb_v_r   <= 1'b0;
      wb_rd_r  <= {REG_AW{1'b0}};
      wb_we_r  <= 1'b0;
      wb_ld_r  <= 1'b0;
      sel_a_r  <= SEL_RF;
      sel_b_r  <= SEL_RF;
    end else if (stall_in) begin
      ex_v_r   <= ex_v_r;
      ex_rd_r  <= ex_rd_r;
      ex_we_r  <= ex_we_r;
      ex_ld_r  <= ex_ld_r;
      mem_v_r  <= mem_v_r;
      mem_rd_r <= mem_rd_r;
      mem_we_r <= mem_we_r;
      mem_ld_r <= mem_ld_r;
      wb_v_r   <= wb_v_r;
      wb_rd_r  <= wb_rd_r;
      wb_we_r  <= wb_we_r;
      wb_ld_r  <= wb_ld_r;
      sel_a_r  <= sel_a_r;
      sel_b_r  <= sel_b_r;
    end else begin
      mem_v_r  <= ex_v_r;
      mem_rd_r <= ex_rd_r;
      mem_we_r <= ex_we_r;
      mem_ld_r <= ex_ld_r;
      wb_v_r   <= mem_v_r;
      wb_rd_r  <= mem_rd_r;
      wb_we_r  <= mem_we_r;
      wb_ld_r  <= mem_ld_r;
      if (flush || hazard_s) begin
        ex_v_r  <= 1'b0;
        ex_rd_r <= {REG_AW{1'b0}};
        ex_we_r <= 1'b0;
        ex_ld_r <= 1'b0;
        sel_a_r <= SEL_RF;
        sel_b_r <= SEL_RF;
      end else begin
        ex_v_r  <= id_valid;
        ex_rd_r <= id_rd;
        ex_we_r <= id_we;
        ex_ld_r <= id_is_load;
        sel_a_r <= sel_a_s;
        sel_b_r <= sel_b_s;
      end
    end
  end

endmodule

// File: tb/tb_fwd_select_unit.sv
// Self-checking bench for fwd_select_unit: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// history-based reference model.
module tb_fwd_select_unit;

  logic       clk;
  logic       rst_n;
  logic       id_valid;
  logic [3:0] id_rn;
  logic       id_rn_used;
  logic [3:0] id_rm;
  logic       id_rm_used;
  logic [3:0] id_rd;
  logic       id_we;
  logic       id_is_load;
  logic       stall_in;
  logic       flush;
  logic [1:0] sel_a;
  logic [1:0] sel_b;
  logic       ex_valid;
  logic       hazard_stall;

  int vectors    = 0;
  int miscompares = 0;

  fwd_select_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_valid     (id_valid),
    .id_rn        (id_rn),
    .id_rn_used   (id_rn_used),
    .id_rm        (id_rm),
    .id_rm_used   (id_rm_used),
    .id_rd        (id_rd),
    .id_we        (id_we),
    .id_is_load   (id_is_load),
    .stall_in     (stall_in),
    .flush        (flush),
    .sel_a        (sel_a),
    .sel_b        (sel_b),
    .ex_valid     (ex_valid),
    .hazard_stall (hazard_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // hist[0] is the instruction most recently issued into EX, hist[1] the one
  // before it, hist[2] the one before that (bubbles included).
  typedef struct {
    bit       v;
    bit [3:0] rd;
    bit       we;
    bit       ld;
  } instr_t;

  instr_t   hist [3];
  bit [1:0] m_sel_a;
  bit [1:0] m_sel_b;
  bit       seen_reset = 1'b0;

  function automatic bit writes(input instr_t i, input logic [3:0] r);
    return i.v && i.we && (i.rd != 4'd15) && (i.rd == r);
  endfunction

  // Select = 1 + age of the youngest in-flight writer of the source.
  function automatic bit [1:0] m_sel(input logic [3:0] src, input logic used);
    if (!id_valid || !used || src == 4'd15) return 2'd0;
    for (int k = 0; k < 3; k++)
      if (writes(hist[k], src)) return 2'(k + 1);
    return 2'd0;
  endfunction

  function automatic bit m_load_use();
    if (!id_valid || !hist[0].ld) return 1'b0;
    return (id_rn_used && writes(hist[0], id_rn)) ||
           (id_rm_used && writes(hist[0], id_rm));
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) hist[k] = '{1'b0, 4'd0, 1'b0, 1'b0};
      m_sel_a    = 2'd0;
      m_sel_b    = 2'd0;
      seen_reset = 1'b1;
    end else if (!stall_in) begin
      instr_t nxt;
      if (flush || m_load_use()) begin
        nxt     = '{1'b0, 4'd0, 1'b0, 1'b0};
        m_sel_a = 2'd0;
        m_sel_b = 2'd0;
      end else begin
        nxt     = '{id_valid, id_rd, id_we, id_is_load};
        m_sel_a = m_sel(id_rn, id_rn_used);
        m_sel_b = m_sel(id_rm, id_rm_used);
      end
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = nxt;
    end
  end

  task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (seen_reset) begin
      check("model_sel_a", sel_a, m_sel_a);
      check("model_sel_b", sel_b, m_sel_b);
      check("model_ex_valid", {1'b0, ex_valid}, {1'b0, hist[0].v});
      check("model_hazard", {1'b0, hazard_stall}, {1'b0, m_load_use() && !flush});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input bit [3:0] rn, input bit rnu,
                       input bit [3:0] rm, input bit rmu,
                       input bit [3:0] rd, input bit we, input bit ld);
    id_valid   = v;
    id_rn      = rn;
    id_rn_used = rnu;
    id_rm      = rm;
    id_rm_used = rmu;
    id_rd      = rd;
    id_we      = we;
    id_is_load = ld;
  endtask

  task automatic idle(input int n);
    drive(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    repeat (n) tick();
  endtask

  initial begin
    bit [1:0] exp_gap [4];
    exp_gap[0] = 2'b01; exp_gap[1] = 2'b10; exp_gap[2] = 2'b11; exp_gap[3] = 2'b00;

    // Reset with random decode inputs.
    rst_n    = 1'b0;
    stall_in = 1'b0;
    flush    = 1'b0;
    drive(1'b1, 4'($urandom), 1'b1, 4'($urandom), 1'b1, 4'($urandom), 1'b1, 1'b1);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    check("reset_sel_a", sel_a, 2'b00);
    check("reset_sel_b", sel_b, 2'b00);
    check("reset_ex_valid", {1'b0, ex_valid}, 2'b00);
    check("reset_hazard", {1'b0, hazard_stall}, 2'b00);
    idle(3);

    // Producer distance: ADD r3, gap independents, then ADD r4,r3,r3.
    for (int gap = 0; gap < 4; gap++) begin
      idle(3);
      drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd3, 1'b1, 1'b0);
      tick();
      for (int j = 0; j < gap; j++) begin
        drive(1'b1, 4'd10, 1'b1, 4'd11, 1'b1, 4'(9 + j), 1'b1, 1'b0);
        tick();
      end
      drive(1'b1, 4'd3, 1'b1, 4'd3, 1'b1, 4'd4, 1'b1, 1'b0);
      tick();
      check($sformatf("gap%0d_sel_a", gap), sel_a, exp_gap[gap]);
      check($sformatf("gap%0d_sel_b", gap), sel_b, exp_gap[gap]);
    end

    // Load-use: LDR r2 then ADD r5,r2,r1.
    idle(3);
    drive(1'b1, 4'd0, 1'b1, 4'd0, 1'b0, 4'd2, 1'b1, 1'b1);
    tick();
    drive(1'b1, 4'd2, 1'b1, 4'd1, 1'b1, 4'd5, 1'b1, 1'b0);
    #1;
    check("lu_hazard_on", {1'b0, hazard_stall}, 2'b01);
    tick();
    check("lu_bubble", {1'b0, ex_valid}, 2'b00);
    check("lu_bubble_sel_a", sel_a, 2'b00);
    #1;
    check("lu_hazard_off", {1'b0, hazard_stall}, 2'b00);
    tick();
    check("lu_add_valid", {1'b0, ex_valid}, 2'b01);
    check("lu_add_sel_a", sel_a, 2'b10);
    check("lu_add_sel_b", sel_b, 2'b00);

    // PC never forwarded.
    idle(3);
    drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd15, 1'b1, 1'b0);
    tick();
    drive(1'b1, 4'd15, 1'b1, 4'd15, 1'b1, 4'd6, 1'b1, 1'b0);
    tick();
    check("pc_sel_a", sel_a, 2'b00);
    check("pc_sel_b", sel_b, 2'b00);

    // Youngest writer wins: r7 in EX and in WB.
    idle(3);
    drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd7, 1'b1, 1'b0);
    tick();
    drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd9, 1'b1, 1'b0);
    tick();
    drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd7, 1'b1, 1'b0);
    tick();
    drive(1'b1, 4'd7, 1'b1, 4'd8, 1'b0, 4'd12, 1'b1, 1'b0);
    tick();
    check("young_sel_a", sel_a, 2'b01);
    check("young_sel_b", sel_b, 2'b00);

    // Flush during load-use: no stall, bubble, load moves on to MEM.
    idle(3);
    drive(1'b1, 4'd0, 1'b1, 4'd0, 1'b0, 4'd2, 1'b1, 1'b1);
    tick();
    drive(1'b1, 4'd2, 1'b1, 4'd1, 1'b1, 4'd5, 1'b1, 1'b0);
    flush = 1'b1;
    #1;
    check("fl_hazard", {1'b0, hazard_stall}, 2'b00);
    tick();
    flush = 1'b0;
    check("fl_bubble", {1'b0, ex_valid}, 2'b00);
    drive(1'b1, 4'd2, 1'b1, 4'd0, 1'b0, 4'd6, 1'b1, 1'b0);
    #1;
    check("fl_no_hazard", {1'b0, hazard_stall}, 2'b00);
    tick();
    check("fl_load_in_mem", sel_a, 2'b10);

    // Freeze for 3 cycles with SEL_A = 01 in EX; flush pulse ignored.
    idle(3);
    drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd3, 1'b1, 1'b0);
    tick();
    drive(1'b1, 4'd3, 1'b1, 4'd3, 1'b1, 4'd4, 1'b1, 1'b0);
    tick();
    check("st_pre_sel_a", sel_a, 2'b01);
    drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd9, 1'b1, 1'b0);
    stall_in = 1'b1;
    for (int c = 0; c < 3; c++) begin
      flush = (c == 1);
      tick();
      check($sformatf("st%0d_sel_a", c), sel_a, 2'b01);
      check($sformatf("st%0d_ex_valid", c), {1'b0, ex_valid}, 2'b01);
    end
    stall_in = 1'b0;
    flush    = 1'b0;
    drive(1'b1, 4'd4, 1'b1, 4'd3, 1'b1, 4'd12, 1'b1, 1'b0);
    tick();
    check("st_tags_ex", sel_a, 2'b01);
    check("st_tags_mem", sel_b, 2'b10);

    // Randomized traffic on a small register set to provoke matches.
    for (int n = 0; n < 3000; n++) begin
      bit [3:0] r [3];
      for (int k = 0; k < 3; k++) begin
        r[k] = 4'($urandom_range(0, 5));
        if (r[k] == 4'd5) r[k] = 4'd15;
      end
      rst_n    = ($urandom_range(0, 99) != 0);
      stall_in = ($urandom_range(0, 5) == 0);
      flush    = ($urandom_range(0, 7) == 0);
      drive(($urandom_range(0, 7) != 0), r[0], 1'($urandom), r[1], 1'($urandom),
            r[2], 1'($urandom), ($urandom_range(0, 2) == 0));
      tick();
    end

    rst_n    = 1'b1;
    stall_in = 1'b0;
    flush    = 1'b0;
    idle(2);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fwd_select_unit.md
Name: fwd_select_unit

Overview:
- Operand-forwarding controller for the ARM integer pipeline. It generates the registered 2-bit selects that drive the two EX-stage operand MUX4 instances (operand A and operand B).
- It tracks destination-register tags of in-flight instructions in EX, MEM and WB, and picks the youngest matching producer.
- It detects load-use hazards and requests a one-cycle decode stall, inserting a bubble.

Parameters:
- REG_AW, 4, register index width (16 architectural registers).
- PC_REG, 15, register index of PC; never forwarded, never tracked.

Ports:
- CLK  input  1  system clock, rising edge.
- RST_N  input  1  synchronous reset, active-low.
- ID_VALID  input  1  decode stage holds a valid instruction.
- ID_RN  input  REG_AW  first source register index.
- ID_RN_USED  input  1  ID_RN is actually read.
- ID_RM  input  REG_AW  second source register index.
- ID_RM_USED  input  1  ID_RM is actually read.
- ID_RD  input  REG_AW  destination register index.
- ID_WE  input  1  instruction writes ID_RD.
- ID_IS_LOAD  input  1  instruction is a load; result is available only from WB.
- STALL_IN  input  1  global pipeline freeze (memory wait).
- FLUSH  input  1  kill the decode instruction (taken branch).
- SEL_A  output  2  operand-A MUX4 select, applied in EX.
- SEL_B  output  2  operand-B MUX4 select, applied in EX.
- EX_VALID  output  1  EX stage holds a valid, non-bubble instruction.
- HAZARD_STALL  output  1  combinational; hold fetch/decode this cycle.

Behaviour:
- EX-stage MUX4 inputs are wired as follows:
  - IN0 = register-file operand.
  - IN1 = MEM-stage result.
  - IN2 = WB-stage result.
  - IN3 = retire latch, which holds the value written one cycle earlier.
- Internal tag registers per stage S in {EX, MEM, WB}: S_v, S_rd, S_we, S_ld. A producer is live when S_v & S_we & (S_rd != PC_REG).
- Select computation for source X (RN or RM), done in the decode cycle and registered on advance:
  - Select is 00 if !ID_VALID, or !X_USED, or X == PC_REG.
  - Else 01 if it matches the live EX tag (the producer will be in MEM next cycle).
  - Else 10 if it matches the live MEM tag.
  - Else 11 if it matches the live WB tag.
  - Else 00.
  - Youngest match wins. The same rule computes SEL_A from RN and SEL_B from RM.
- Load-use hazard:
  - Condition: ID_VALID & EX_v & EX_ld & EX_we & EX_rd != PC_REG & ((RN_USED & RN == EX_rd) | (RM_USED & RM == EX_rd)).
  - HAZARD_STALL is this condition gated by !FLUSH.
  - On the next edge the bubble enters EX (EX_v = 0, SEL_A/SEL_B = 00). MEM and WB advance normally.
  - In the following cycle the load sits in MEM and the match yields 10.
- Advance priority on each rising edge, highest first:
  1. !RST_N: all S_v = 0, SEL_A = SEL_B = 00, EX_VALID = 0. HAZARD_STALL is therefore 0 from the first post-reset cycle.
  2. STALL_IN: every register holds. FLUSH is ignored; the branch unit holds FLUSH until STALL_IN drops.
  3. FLUSH: EX loads a bubble and SEL outputs go to 00. MEM <- EX and WB <- MEM; the old WB retires.
  4. HAZARD_STALL: EX loads a bubble; MEM and WB advance.
  5. Normal:
     - EX <- {ID_VALID, ID_RD, ID_WE, ID_IS_LOAD}.
     - SEL_A and SEL_B take the computed values.
     - MEM <- EX, WB <- MEM.
- EX_VALID mirrors EX_v.
- Latency: SEL is valid exactly one cycle after the decode cycle that computed it, and is held through STALL_IN.
- A store or compare has ID_WE = 0 and creates no producer. A bubble or flushed slot is never matched.
- RN == RM with a single producer: SEL_A and SEL_B take identical values.
- A load hitting in WB or in the retire latch causes no stall.
- A reset asserted mid-operation discards all in-flight tags within one cycle.

Decomposition:
- Shared package: REG_AW and PC_REG defaults, plus named SEL encodings SEL_RF = 00, SEL_MEM = 01, SEL_WB = 10, SEL_RET = 11 (must match the MUX4 input wiring).
- Sub-module fwd_match:
  - Inputs: one source index, its used bit, and the three stage tags.
  - Outputs: the 2-bit select and a load-hit flag.
  - Combinational; instantiated twice (A and B). Tag registers and advance logic stay in the top level.

Test Plan:
- Reset with RST_N = 0 for 2 cycles, ID inputs random -> SEL_A = SEL_B = 00, EX_VALID = 0, HAZARD_STALL = 0 on the first cycle after release.
- Back-to-back ADD r3 then ADD r4,r3,r3 -> second instruction in EX has SEL_A = SEL_B = 01. With one independent instruction between them -> 10. With two between -> 11. With three between -> 00.
- LDR r2 followed by ADD r5,r2,r1 -> HAZARD_STALL = 1 for exactly one cycle, a bubble in EX (EX_VALID = 0), then the ADD in EX with SEL_A = 10 and SEL_B = 00.
- Source r15 with an older write to r15 in flight -> SEL = 00. Source r7 with writers of r7 in both EX and WB -> SEL = 01 (youngest wins).
- FLUSH asserted during the load-use case -> HAZARD_STALL = 0, EX bubble, the older load continues to MEM.
- STALL_IN held 3 cycles with SEL_A = 01 in EX -> SEL_A, EX_VALID and all tags unchanged. FLUSH pulsed during the freeze has no effect.
